// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the freq_meter block.
// Used by freq_meter.sv and freq_meter_sync_edge.sv.
package freq_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Gate counter width for a window of `win` cycles (at least 1 bit).
  function automatic int gate_w(input int win);
    return (win < 2) ? 1 : $clog2(win);
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer plus one history flop.
// o_edge is a one-cycle rising-edge strobe of the synchronized input.
module sync_edge
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // NOTE: non-blocking assignments make each flop capture its predecessor's
  // pre-edge value, giving a real three-stage shift instead of a wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over WIN = F0/GATE_HZ cycles.
// Optional saturation and ovf flag: define FREQ_METER_OVF_EN (default: wrap, ovf=0).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int F0      = 50_000_000,
  parameter int GATE_HZ = 1_000,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic             busy,
  output logic [CNT_W-1:0] res_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             ovf,
  output logic             drop
);

  localparam int               WIN       = F0 / GATE_HZ;
  localparam int               GW        = gate_w(WIN);
  localparam logic [GW-1:0]    GATE_LAST = GW'(WIN - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_res_cnt;
  logic             r_res_valid;
  logic             r_drop;
  logic             w_edge;
  logic             w_close;
  logic [CNT_W-1:0] w_result;

  sync_edge u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .o_edge (w_edge)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en) w_state_nxt = ST_IDLE;
        else     w_close     = (r_gate_cnt == GATE_LAST);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // w_result is both the next edge count and, on the closing cycle, the
  // window result, so an edge on the closing cycle lands in that window.
`ifdef FREQ_METER_OVF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic r_sat;
  logic r_ovf;
  logic w_edge_full;
  logic w_result_sat;

  assign w_edge_full  = (r_edge_cnt == CNT_MAX);
  assign w_result     = (w_edge && !w_edge_full) ? r_edge_cnt + CNT_ONE : r_edge_cnt;
  assign w_result_sat = r_sat | (w_edge & w_edge_full);

  // Sticky per-window flag: an increment was lost to saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (r_state == ST_IDLE || w_close) begin
      r_sat <= 1'b0;
    end else if (en && w_edge && w_edge_full) begin
      r_sat <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_close) r_ovf <= w_result_sat;
  end

  assign ovf = r_ovf;
`else
  assign w_result = w_edge ? r_edge_cnt + CNT_ONE : r_edge_cnt;
  assign ovf      = 1'b0;
`endif

  // State register and window counters; counters sit at 0 throughout IDLE,
  // so every entry into RUN starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
      end else if (en) begin
        if (w_close) begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
        end else begin
          r_gate_cnt <= r_gate_cnt + GATE_ONE;
          r_edge_cnt <= w_result;
        end
      end
    end
  end

  // Result register and handshake. A close always wins over an acceptance
  // on the same cycle; only a close over an unaccepted result is a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_cnt   <= '0;
      r_res_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_close & r_res_valid & ~res_ready;
      if (w_close) begin
        r_res_cnt   <= w_result;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign res_cnt   = r_res_cnt;
  assign res_valid = r_res_valid;
  assign drop      = r_drop;

endmodule
